// File: rtl/morse_pkg.sv
// Shared definitions for the Morse letter assembler: FSM states and letter codes.
package morse_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COLLECT   = 2'd1,
        ST_WAIT_WORD = 2'd2
    } state_e;

    localparam logic [4:0] LETTER_INVALID = 5'd31;

    localparam logic [4:0] LTR_A = 5'd0;
    localparam logic [4:0] LTR_B = 5'd1;
    localparam logic [4:0] LTR_C = 5'd2;
    localparam logic [4:0] LTR_D = 5'd3;
    localparam logic [4:0] LTR_E = 5'd4;
    localparam logic [4:0] LTR_F = 5'd5;
    localparam logic [4:0] LTR_G = 5'd6;
    localparam logic [4:0] LTR_H = 5'd7;
    localparam logic [4:0] LTR_I = 5'd8;
    localparam logic [4:0] LTR_J = 5'd9;
    localparam logic [4:0] LTR_K = 5'd10;
    localparam logic [4:0] LTR_L = 5'd11;
    localparam logic [4:0] LTR_M = 5'd12;
    localparam logic [4:0] LTR_N = 5'd13;
    localparam logic [4:0] LTR_O = 5'd14;
    localparam logic [4:0] LTR_P = 5'd15;
    localparam logic [4:0] LTR_Q = 5'd16;
    localparam logic [4:0] LTR_R = 5'd17;
    localparam logic [4:0] LTR_S = 5'd18;
    localparam logic [4:0] LTR_T = 5'd19;
    localparam logic [4:0] LTR_U = 5'd20;
    localparam logic [4:0] LTR_V = 5'd21;
    localparam logic [4:0] LTR_W = 5'd22;
    localparam logic [4:0] LTR_X = 5'd23;
    localparam logic [4:0] LTR_Y = 5'd24;
    localparam logic [4:0] LTR_Z = 5'd25;

endpackage

// File: rtl/morse_letter_lut.sv
// Combinational decode of a stored dot/dash pattern to a letter code.
// Symbol k sits in bit k (first symbol = bit 0); 1 = dash, 0 = dot.
module morse_letter_lut
    import morse_pkg::*;
(
    input  logic [2:0] i_len,
    input  logic [3:0] i_bits,
    output logic [4:0] o_code,
    output logic       o_err
);

    always_comb begin
        o_code = LETTER_INVALID;
        unique case (i_len)
            3'd1: o_code = i_bits[0] ? LTR_T : LTR_E;
            3'd2: begin
                unique case (i_bits[1:0])
                    2'b00: o_code = LTR_I;
                    2'b10: o_code = LTR_A;
                    2'b01: o_code = LTR_N;
                    2'b11: o_code = LTR_M;
                endcase
            end
            3'd3: begin
                unique case (i_bits[2:0])
                    3'b000: o_code = LTR_S;
                    3'b100: o_code = LTR_U;
                    3'b010: o_code = LTR_R;
                    3'b110: o_code = LTR_W;
                    3'b001: o_code = LTR_D;
                    3'b101: o_code = LTR_K;
                    3'b011: o_code = LTR_G;
                    3'b111: o_code = LTR_O;
                endcase
            end
            3'd4: begin
                unique case (i_bits)
                    4'b0000: o_code = LTR_H;
                    4'b1000: o_code = LTR_V;
                    4'b0100: o_code = LTR_F;
                    4'b0010: o_code = LTR_L;
                    4'b0110: o_code = LTR_P;
                    4'b1110: o_code = LTR_J;
                    4'b0001: o_code = LTR_B;
                    4'b1001: o_code = LTR_X;
                    4'b0101: o_code = LTR_C;
                    4'b1101: o_code = LTR_Y;
                    4'b0011: o_code = LTR_Z;
                    4'b1011: o_code = LTR_Q;
                    default: o_code = LETTER_INVALID;
                endcase
            end
            default: o_code = LETTER_INVALID;
        endcase
        o_err = (o_code == LETTER_INVALID);
    end

endmodule

// File: rtl/morse_letter_assembler.sv
// Collects dot/dash pulses into a letter, closes it after a letter gap of silent
// ticks, and flags a word gap after a longer silence.
module morse_letter_assembler
    import morse_pkg::*;
#(
    parameter int LETTER_GAP_TICKS = 3,
    parameter int WORD_GAP_TICKS   = 7,
    parameter int CNT_W            = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       key,
    input  logic       dot_in,
    input  logic       dash_in,
    output logic [4:0] letter_code,
    output logic       letter_valid,
    output logic       letter_err,
    output logic       word_gap
);

    localparam logic [CNT_W-1:0] LETTER_GAP = CNT_W'(LETTER_GAP_TICKS);
    localparam logic [CNT_W-1:0] WORD_GAP   = CNT_W'(WORD_GAP_TICKS);

    state_e           r_state;
    logic [2:0]       r_sym_len;
    logic [3:0]       r_sym_bits;
    logic [CNT_W-1:0] r_gap_cnt;
    logic             r_ovf;
    logic [4:0]       r_letter_code;
    logic             r_letter_valid;
    logic             r_letter_err;
    logic             r_word_gap;

    logic       w_sym_ev;
    logic       w_close;
    logic       w_word_end;
    logic       w_reject;
    logic [2:0] w_base_len;
    logic [3:0] w_base_bits;
    logic       w_base_ovf;
    logic [3:0] w_new_bits;
    logic [4:0] w_lut_code;
    logic       w_lut_err;

    morse_letter_lut u_lut (
        .i_len  (r_sym_len),
        .i_bits (r_sym_bits),
        .o_code (w_lut_code),
        .o_err  (w_lut_err)
    );

    // A symbol landing on the closing cycle starts the next letter from an empty buffer.
    always_comb begin
        w_sym_ev    = dot_in | dash_in;
        w_close     = (r_state == ST_COLLECT) && (r_gap_cnt >= LETTER_GAP);
        w_word_end  = (r_state == ST_WAIT_WORD) && (r_gap_cnt >= WORD_GAP) && !w_sym_ev;
        w_base_len  = w_close ? 3'd0 : r_sym_len;
        w_base_bits = w_close ? 4'd0 : r_sym_bits;
        w_base_ovf  = w_close ? 1'b0 : r_ovf;
        w_reject    = (dot_in & dash_in) || (w_base_len == 3'd4);
        w_new_bits  = w_base_bits;
        w_new_bits[w_base_len[1:0]] = dash_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_sym_len      <= 3'd0;
            r_sym_bits     <= 4'd0;
            r_gap_cnt      <= '0;
            r_ovf          <= 1'b0;
            r_letter_code  <= 5'd0;
            r_letter_valid <= 1'b0;
            r_letter_err   <= 1'b0;
            r_word_gap     <= 1'b0;
        end else begin
            r_letter_valid <= 1'b0;
            r_word_gap     <= 1'b0;

            if (w_sym_ev || key || w_word_end)
                r_gap_cnt <= '0;
            else if (tick && (r_state != ST_IDLE) && (r_gap_cnt < WORD_GAP))
                r_gap_cnt <= r_gap_cnt + 1'b1;

            if (w_sym_ev) begin
                r_state <= ST_COLLECT;
                if (w_reject) begin
                    r_sym_len  <= w_base_len;
                    r_sym_bits <= w_base_bits;
                    r_ovf      <= 1'b1;
                end else begin
                    r_sym_len  <= w_base_len + 3'd1;
                    r_sym_bits <= w_new_bits;
                    r_ovf      <= w_base_ovf;
                end
            end else if (w_close) begin
                r_state    <= ST_WAIT_WORD;
                r_sym_len  <= 3'd0;
                r_sym_bits <= 4'd0;
                r_ovf      <= 1'b0;
            end else if (w_word_end) begin
                r_state <= ST_IDLE;
            end

            if (w_close) begin
                r_letter_valid <= 1'b1;
                r_letter_code  <= r_ovf ? LETTER_INVALID : w_lut_code;
                r_letter_err   <= r_ovf | w_lut_err;
            end
            if (w_word_end)
                r_word_gap <= 1'b1;
        end
    end

    assign letter_code  = r_letter_code;
    assign letter_valid = r_letter_valid;
    assign letter_err   = r_letter_err;
    assign word_gap     = r_word_gap;

endmodule

// File: tb/tb_morse_letter_assembler.sv
// Directed bench for morse_letter_assembler: letter decode, gaps, overflow, key hold, reset.
module tb_morse_letter_assembler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick = 1'b0;
    logic       key = 1'b0;
    logic       dot_in = 1'b0;
    logic       dash_in = 1'b0;
    logic [4:0] letter_code;
    logic       letter_valid;
    logic       letter_err;
    logic       word_gap;

    int tests = 0;
    int fails = 0;
    int lv_cnt = 0;
    int wg_cnt = 0;
    int both_cnt = 0;
    logic [4:0] codes[$];
    logic       errs[$];

    morse_letter_assembler #(
        .LETTER_GAP_TICKS (3),
        .WORD_GAP_TICKS   (7),
        .CNT_W            (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .tick         (tick),
        .key          (key),
        .dot_in       (dot_in),
        .dash_in      (dash_in),
        .letter_code  (letter_code),
        .letter_valid (letter_valid),
        .letter_err   (letter_err),
        .word_gap     (word_gap)
    );

    always #5 clk = ~clk;

    // One clock: drive at negedge, observe outputs at the following negedge.
    task automatic cyc(input logic d, input logic s, input logic t);
        dot_in = d; dash_in = s; tick = t;
        @(negedge clk);
        dot_in = 1'b0; dash_in = 1'b0; tick = 1'b0;
        if (letter_valid) begin
            lv_cnt++;
            codes.push_back(letter_code);
            errs.push_back(letter_err);
        end
        if (word_gap) wg_cnt++;
        if (letter_valid && word_gap) both_cnt++;
    endtask

    task automatic dot();  cyc(1'b1, 1'b0, 1'b0); endtask
    task automatic dash(); cyc(1'b0, 1'b1, 1'b0); endtask
    task automatic idle(input int n); for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0); endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b0, 1'b1);
            cyc(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic clr();
        lv_cnt = 0; wg_cnt = 0;
        codes.delete(); errs.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({letter_code, letter_valid, letter_err, word_gap} !== 8'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 0", {letter_code, letter_valid, letter_err, word_gap});
        end
        reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_letter_a();
        clr();
        dot(); idle(3); dash();
        ticks(2);
        cyc(1'b0, 1'b0, 1'b1);
        tests++;
        if (letter_valid !== 1'b0) begin
            fails++; $display("FAIL a_latency_early: letter_valid=%b expected 0", letter_valid);
        end
        cyc(1'b0, 1'b0, 1'b0);
        tests++;
        if ({letter_valid, letter_code, letter_err} !== {1'b1, 5'd0, 1'b0}) begin
            fails++;
            $display("FAIL a_letter: valid=%b code=%0d err=%b expected 1 0 0", letter_valid, letter_code, letter_err);
        end
        ticks(4);
        idle(3);
        tests++;
        if (wg_cnt !== 1 || lv_cnt !== 1) begin
            fails++; $display("FAIL a_word_gap: wg=%0d lv=%0d expected 1 1", wg_cnt, lv_cnt);
        end
    endtask

    task automatic test_sos();
        clr();
        dash(); ticks(1); dot(); ticks(1); dot(); ticks(1); dot();
        ticks(3);
        tests++;
        if (lv_cnt !== 1 || codes[0] !== 5'd1) begin
            fails++; $display("FAIL b_letter: lv=%0d code=%0d expected 1 1", lv_cnt, lv_cnt > 0 ? codes[0] : 5'd0);
        end
        ticks(4); idle(1);
        clr();
        for (int l = 0; l < 3; l++) begin
            for (int s = 0; s < 3; s++) begin
                if (l == 1) dash(); else dot();
                if (s < 2) ticks(1);
            end
            ticks(3);
        end
        tests++;
        if (lv_cnt !== 3 || codes[0] !== 5'd18 || codes[1] !== 5'd14 || codes[2] !== 5'd18) begin
            fails++; $display("FAIL sos_codes: lv=%0d expected 3 letters 18 14 18", lv_cnt);
        end
        ticks(3);
        tests++;
        if (wg_cnt !== 0) begin
            fails++; $display("FAIL sos_early_word_gap: wg=%0d expected 0", wg_cnt);
        end
        ticks(1); idle(1);
        tests++;
        if (wg_cnt !== 1) begin
            fails++; $display("FAIL sos_word_gap: wg=%0d expected 1", wg_cnt);
        end
    endtask

    task automatic test_overflow();
        clr();
        repeat (5) begin dot(); idle(1); end
        ticks(3);
        repeat (4) begin dash(); idle(1); end
        ticks(3);
        dot(); ticks(3);
        tests++;
        if (lv_cnt !== 3) begin
            fails++; $display("FAIL ovf_count: lv=%0d expected 3", lv_cnt);
        end else begin
            tests++;
            if (codes[0] !== 5'd31 || errs[0] !== 1'b1) begin
                fails++; $display("FAIL ovf_five_dots: code=%0d err=%b expected 31 1", codes[0], errs[0]);
            end
            tests++;
            if (codes[1] !== 5'd31 || errs[1] !== 1'b1) begin
                fails++; $display("FAIL invalid_4dash: code=%0d err=%b expected 31 1", codes[1], errs[1]);
            end
            tests++;
            if (codes[2] !== 5'd4 || errs[2] !== 1'b0) begin
                fails++; $display("FAIL after_ovf_e: code=%0d err=%b expected 4 0", codes[2], errs[2]);
            end
        end
        ticks(4); idle(1);
    endtask

    task automatic test_key_hold();
        clr();
        dot();
        key = 1'b1;
        ticks(10);
        key = 1'b0;
        tests++;
        if (lv_cnt !== 0) begin
            fails++; $display("FAIL key_hold: lv=%0d expected 0", lv_cnt);
        end
        ticks(3);
        tests++;
        if (lv_cnt !== 1 || codes[0] !== 5'd4) begin
            fails++; $display("FAIL key_release: lv=%0d expected 1 letter code 4", lv_cnt);
        end
        ticks(4); idle(1);
    endtask

    task automatic test_simultaneous();
        clr();
        dot(); ticks(2);
        cyc(1'b1, 1'b0, 1'b1);
        ticks(2);
        tests++;
        if (lv_cnt !== 0) begin
            fails++; $display("FAIL sym_tick_gap_clear: lv=%0d expected 0", lv_cnt);
        end
        ticks(1);
        tests++;
        if (lv_cnt !== 1 || codes[0] !== 5'd8) begin
            fails++; $display("FAIL sym_tick_letter_i: lv=%0d expected 1 letter code 8", lv_cnt);
        end
        ticks(4); idle(1);
    endtask

    task automatic test_reset_mid();
        clr();
        dot(); dash();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({letter_code, letter_valid, letter_err, word_gap} !== 8'd0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got %b expected 0", {letter_code, letter_valid, letter_err, word_gap});
        end
        reset_n = 1'b1;
        ticks(10);
        tests++;
        if (lv_cnt !== 0 || wg_cnt !== 0) begin
            fails++; $display("FAIL reset_mid_silent: lv=%0d wg=%0d expected 0 0", lv_cnt, wg_cnt);
        end
    endtask

    task automatic test_word_interrupt();
        clr();
        dash(); ticks(3);
        tests++;
        if (lv_cnt !== 1 || codes[0] !== 5'd19) begin
            fails++; $display("FAIL int_letter_t: lv=%0d expected 1 letter code 19", lv_cnt);
        end
        ticks(2);
        dot(); ticks(3);
        tests++;
        if (wg_cnt !== 0 || lv_cnt !== 2 || codes[1] !== 5'd4) begin
            fails++; $display("FAIL int_letter_e: wg=%0d lv=%0d expected 0 2 (code 4)", wg_cnt, lv_cnt);
        end
        ticks(4); idle(1);
        tests++;
        if (wg_cnt !== 1) begin
            fails++; $display("FAIL int_word_gap: wg=%0d expected 1", wg_cnt);
        end
    endtask

    task automatic test_invalid_mixed();
        clr();
        dot(); dash(); dot(); dash();
        ticks(3);
        dash(); dash(); dot(); dash();
        ticks(3);
        tests++;
        if (lv_cnt !== 2 || codes[0] !== 5'd31 || errs[0] !== 1'b1 || codes[1] !== 5'd16 || errs[1] !== 1'b0) begin
            fails++; $display("FAIL invalid_dotdash_q: lv=%0d expected 31/err then 16", lv_cnt);
        end
        ticks(4); idle(1);
    endtask

    initial begin
        test_reset();
        test_letter_a();
        test_sos();
        test_overflow();
        test_key_hold();
        test_simultaneous();
        test_invalid_mixed();
        test_reset_mid();
        test_word_interrupt();
        tests++;
        if (both_cnt !== 0) begin
            fails++; $display("FAIL strobe_overlap: both=%0d expected 0", both_cnt);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
